// File: rtl/bcd_display_scan4_if.sv
// Signal bundle between the counter chain and the display scanner.
// The master drives the digit data; the slave (scanner) returns the pin levels.
interface bcd_display_scan4_if;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic [3:0] dp;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp_out;
    logic [3:0] an;

    modport master (
        output d0, d1, d2, d3, dp, blank_lz,
        input  seg, dp_out, an
    );

    modport slave (
        input  d0, d1, d2, d3, dp, blank_lz,
        output seg, dp_out, an
    );
endinterface

// File: rtl/bcd_display_scan4.sv
// Time-multiplexes four BCD digits onto a common-anode 4-digit seven-segment display
// with a per-slot dead time, leading-zero blanking and registered pin outputs.
module bcd_display_scan4 #(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_display_scan4_if.slave   bus
);

    localparam int unsigned      CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [6:0]       SEG_INV  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic             DP_INV   = SEG_ACTIVE_LOW;
    localparam logic [3:0]       AN_INV   = AN_ACTIVE_LOW ? 4'hF : 4'h0;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       index_q, index_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_out_q, dp_out_d;
    logic [3:0]       an_q, an_d;

    logic             dead_s;
    logic             lz3_s, lz2_s, lz1_s;
    logic [3:0]       digit_s;
    logic             blank_s;
    logic             dp_sel_s;
    logic [6:0]       seg_act_s;
    logic             dp_act_s;
    logic [3:0]       an_act_s;

    // With no dead time the comparison would be against zero, so it is removed entirely.
    if (BLANK_CYCLES == 0) begin : g_no_dead
        assign dead_s = 1'b0;
    end else begin : g_dead
        localparam logic [CNT_W-1:0] BLANK_L = CNT_W'(BLANK_CYCLES);
        assign dead_s = (count_q < BLANK_L);
    end

    // A digit is a leading zero only if it and every higher digit are zero; non-BCD counts as non-zero.
    assign lz3_s = bus.blank_lz && (bus.d3 == 4'd0);
    assign lz2_s = lz3_s && (bus.d2 == 4'd0);
    assign lz1_s = lz2_s && (bus.d1 == 4'd0);

    // Prescaler and digit index next state.
    always_comb begin
        count_d = count_q;
        index_d = index_q;
        if (count_q == CNT_LAST) begin
            count_d = '0;
            index_d = index_q + 2'd1;
        end else begin
            count_d = count_q + CNT_ONE;
            index_d = index_q;
        end
    end

    // Select the digit, blanking flag and decimal point for the current slot.
    always_comb begin
        digit_s  = 4'd0;
        blank_s  = 1'b0;
        dp_sel_s = 1'b0;
        case (index_q)
            2'd0: begin digit_s = bus.d0; blank_s = 1'b0;  dp_sel_s = bus.dp[0]; end
            2'd1: begin digit_s = bus.d1; blank_s = lz1_s; dp_sel_s = bus.dp[1]; end
            2'd2: begin digit_s = bus.d2; blank_s = lz2_s; dp_sel_s = bus.dp[2]; end
            2'd3: begin digit_s = bus.d3; blank_s = lz3_s; dp_sel_s = bus.dp[3]; end
            default: begin digit_s = 4'd0; blank_s = 1'b0; dp_sel_s = 1'b0; end
        endcase
    end

    // Active-high pin values, then polarity applied as an XOR mask.
    always_comb begin
        an_act_s  = 4'b0000;
        seg_act_s = 7'h00;
        dp_act_s  = 1'b0;
        if (dead_s) begin
            an_act_s  = 4'b0000;
            seg_act_s = 7'h00;
            dp_act_s  = 1'b0;
        end else begin
            an_act_s  = 4'b0001 << index_q;
            seg_act_s = blank_s ? 7'h00 : bcd_to_seg(digit_s);
            dp_act_s  = dp_sel_s;
        end
        an_d     = an_act_s ^ AN_INV;
        seg_d    = seg_act_s ^ SEG_INV;
        dp_out_d = dp_act_s ^ DP_INV;
    end

    // State and output registers; reset leaves every pin in its inactive level.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            index_q  <= 2'd0;
            seg_q    <= SEG_INV;
            dp_out_q <= DP_INV;
            an_q     <= AN_INV;
        end else begin
            count_q  <= count_d;
            index_q  <= index_d;
            seg_q    <= seg_d;
            dp_out_q <= dp_out_d;
            an_q     <= an_d;
        end
    end

    assign bus.seg    = seg_q;
    assign bus.dp_out = dp_out_q;
    assign bus.an     = an_q;

endmodule

// File: tb/tb_bcd_display_scan4.sv
// Self-checking bench: a cycle model pushes expected pin values at every edge,
// scenario tasks pop and compare them one cycle later, plus fixed-value checks.
module tb_bcd_display_scan4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    localparam int A_DIV  = 4;
    localparam int A_DEAD = 1;
    localparam int B_DIV  = 2;
    localparam int B_DEAD = 0;
    localparam exp_t RST_EXP = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [3:0] d0 = 4'd4, d1 = 4'd3, d2 = 4'd2, d3 = 4'd1;
    logic [3:0] dp = 4'b0000;
    logic       blank_lz = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int ma_cnt = 0, ma_idx = 0;
    int mb_cnt = 0, mb_idx = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    bcd_display_scan4_if bus_a ();
    bcd_display_scan4_if bus_b ();

    assign bus_a.d0 = d0; assign bus_a.d1 = d1; assign bus_a.d2 = d2; assign bus_a.d3 = d3;
    assign bus_a.dp = dp; assign bus_a.blank_lz = blank_lz;
    assign bus_b.d0 = d0; assign bus_b.d1 = d1; assign bus_b.d2 = d2; assign bus_b.d3 = d3;
    assign bus_b.dp = dp; assign bus_b.blank_lz = blank_lz;

    bcd_display_scan4 #(.REFRESH_DIV(A_DIV), .BLANK_CYCLES(A_DEAD)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a));
    bcd_display_scan4 #(.REFRESH_DIV(B_DIV), .BLANK_CYCLES(B_DEAD)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b));

    always #5 clk = ~clk;

    function automatic exp_t calc_exp(input int cnt, input int idx, input int dead_len);
        exp_t e;
        logic [3:0] dig [4];
        bit zero_above;
        bit blanked;
        dig[0] = d0; dig[1] = d1; dig[2] = d2; dig[3] = d3;
        e = RST_EXP;
        if (cnt >= dead_len) begin
            zero_above = 1'b1;
            for (int j = 3; j > idx; j--) if (dig[j] != 4'd0) zero_above = 1'b0;
            blanked = blank_lz && (idx != 0) && zero_above && (dig[idx] == 4'd0);
            e.an      = 4'hF;
            e.an[idx] = 1'b0;
            e.seg     = blanked ? 7'h7F : ~SEG_TAB[dig[idx]];
            e.dp      = ~dp[idx];
        end
        return e;
    endfunction

    function automatic int an_digit(input logic [3:0] an);
        case (an)
            4'hE:    return 0;
            4'hD:    return 1;
            4'hB:    return 2;
            4'h7:    return 3;
            default: return -1;
        endcase
    endfunction

    // Reference model for both instances; the pushed entry is what the pins show after this edge.
    always @(posedge clk) begin
        if (rst_a) begin
            q_a.push_back(RST_EXP); ma_cnt = 0; ma_idx = 0;
        end else begin
            q_a.push_back(calc_exp(ma_cnt, ma_idx, A_DEAD));
            if (ma_cnt == A_DIV - 1) begin ma_cnt = 0; ma_idx = (ma_idx + 1) % 4; end
            else ma_cnt = ma_cnt + 1;
        end
        if (rst_b) begin
            q_b.push_back(RST_EXP); mb_cnt = 0; mb_idx = 0;
        end else begin
            q_b.push_back(calc_exp(mb_cnt, mb_idx, B_DEAD));
            if (mb_cnt == B_DIV - 1) begin mb_cnt = 0; mb_idx = (mb_idx + 1) % 4; end
            else mb_cnt = mb_cnt + 1;
        end
    end

    task automatic test_reset();
        exp_t e;
        @(negedge clk);
        n_chk++;
        if (q_a.size() == 0) begin n_fail++; $display("FAIL reset_sb queue empty"); e = RST_EXP; end
        else e = q_a.pop_front();
        if ({bus_a.an, bus_a.seg, bus_a.dp_out} !== e) begin
            n_fail++; $display("FAIL reset_sb got %h/%h/%b want %h/%h/%b", bus_a.an, bus_a.seg, bus_a.dp_out, e.an, e.seg, e.dp);
        end
        n_chk++;
        if ({bus_a.an, bus_a.seg, bus_a.dp_out} !== {4'hF, 7'h7F, 1'b1}) begin
            n_fail++; $display("FAIL reset_pins got %h/%h/%b want f/7f/1", bus_a.an, bus_a.seg, bus_a.dp_out);
        end
        rst_a = 1'b0;
    endtask

    task automatic test_scan();
        exp_t e;
        logic [3:0] an_pat [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                    4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
        logic [6:0] seg_lit [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            n_chk++;
            e = (q_a.size() != 0) ? q_a.pop_front() : RST_EXP;
            if ({bus_a.an, bus_a.seg, bus_a.dp_out} !== e) begin
                n_fail++; $display("FAIL scan_sb k=%0d got %h/%h/%b want %h/%h/%b", k, bus_a.an, bus_a.seg, bus_a.dp_out, e.an, e.seg, e.dp);
            end
            n_chk++;
            if (bus_a.an !== an_pat[k % 16]) begin
                n_fail++; $display("FAIL scan_an k=%0d got %h want %h", k, bus_a.an, an_pat[k % 16]);
            end
            n_chk++;
            if (an_pat[k % 16] != 4'hF) begin
                if (bus_a.seg !== seg_lit[(k % 16) / 4]) begin
                    n_fail++; $display("FAIL scan_seg k=%0d got %h want %h", k, bus_a.seg, seg_lit[(k % 16) / 4]);
                end
            end else if (bus_a.seg !== 7'h7F) begin
                n_fail++; $display("FAIL scan_dead_seg k=%0d got %h want 7f", k, bus_a.seg);
            end
        end
    endtask

    task automatic test_blank_lz();
        exp_t e;
        int dg;
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd7; blank_lz = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n_chk++;
            e = (q_a.size() != 0) ? q_a.pop_front() : RST_EXP;
            if ({bus_a.an, bus_a.seg, bus_a.dp_out} !== e) begin
                n_fail++; $display("FAIL lz_sb k=%0d got %h/%h/%b want %h/%h/%b", k, bus_a.an, bus_a.seg, bus_a.dp_out, e.an, e.seg, e.dp);
            end
            dg = an_digit(e.an);
            if (dg >= 0) begin
                n_chk++;
                if (bus_a.seg !== ((dg == 0) ? 7'h78 : 7'h7F)) begin
                    n_fail++; $display("FAIL lz_seg digit=%0d got %h want %h", dg, bus_a.seg, (dg == 0) ? 7'h78 : 7'h7F);
                end
            end
        end
    endtask

    task automatic test_all_zero();
        exp_t e;
        int dg;
        d0 = 4'd0;
        for (int ph = 0; ph < 2; ph++) begin
            blank_lz = (ph == 0);
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                n_chk++;
                e = (q_a.size() != 0) ? q_a.pop_front() : RST_EXP;
                if ({bus_a.an, bus_a.seg, bus_a.dp_out} !== e) begin
                    n_fail++; $display("FAIL zero_sb ph=%0d k=%0d got %h/%h/%b want %h/%h/%b", ph, k, bus_a.an, bus_a.seg, bus_a.dp_out, e.an, e.seg, e.dp);
                end
                dg = an_digit(e.an);
                if (dg >= 0) begin
                    n_chk++;
                    if (bus_a.seg !== ((ph == 0 && dg != 0) ? 7'h7F : 7'h40)) begin
                        n_fail++; $display("FAIL zero_seg ph=%0d digit=%0d got %h", ph, dg, bus_a.seg);
                    end
                end
            end
        end
    endtask

    task automatic test_non_bcd_dp();
        exp_t e;
        int dg;
        d3 = 4'd1; d2 = 4'd2; d1 = 4'hC; d0 = 4'd4; dp = 4'b0010; blank_lz = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n_chk++;
            e = (q_a.size() != 0) ? q_a.pop_front() : RST_EXP;
            if ({bus_a.an, bus_a.seg, bus_a.dp_out} !== e) begin
                n_fail++; $display("FAIL dp_sb k=%0d got %h/%h/%b want %h/%h/%b", k, bus_a.an, bus_a.seg, bus_a.dp_out, e.an, e.seg, e.dp);
            end
            dg = an_digit(e.an);
            n_chk++;
            if (bus_a.dp_out !== ((dg == 1) ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL dp_out digit=%0d got %b", dg, bus_a.dp_out);
            end
            if (dg == 1) begin
                n_chk++;
                if (bus_a.seg !== 7'h3F) begin
                    n_fail++; $display("FAIL dash_seg got %h want 3f", bus_a.seg);
                end
            end
        end
        dp = 4'b0000;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit found;
        logic [3:0] an_after [5] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF};
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            n_chk++;
            e = (q_a.size() != 0) ? q_a.pop_front() : RST_EXP;
            if ({bus_a.an, bus_a.seg, bus_a.dp_out} !== e) begin
                n_fail++; $display("FAIL mid_sb k=%0d got %h/%h/%b want %h/%h/%b", k, bus_a.an, bus_a.seg, bus_a.dp_out, e.an, e.seg, e.dp);
            end
            if (ma_idx == 2 && ma_cnt == 3) found = 1'b1;
        end
        n_chk++;
        if (!found) begin n_fail++; $display("FAIL mid_wait slot idx2/cnt3 not reached within 20 cycles"); end
        rst_a = 1'b1;
        @(negedge clk);
        e = (q_a.size() != 0) ? q_a.pop_front() : RST_EXP;
        n_chk++;
        if ({bus_a.an, bus_a.seg, bus_a.dp_out} !== {4'hF, 7'h7F, 1'b1}) begin
            n_fail++; $display("FAIL mid_reset got %h/%h/%b want f/7f/1", bus_a.an, bus_a.seg, bus_a.dp_out);
        end
        rst_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            e = (q_a.size() != 0) ? q_a.pop_front() : RST_EXP;
            n_chk++;
            if (bus_a.an !== an_after[k]) begin
                n_fail++; $display("FAIL mid_restart k=%0d got %h want %h", k, bus_a.an, an_after[k]);
            end
        end
    endtask

    task automatic test_no_dead();
        exp_t e;
        logic [3:0] prev_an;
        int run;
        bit have_prev;
        @(negedge clk);
        q_b.delete();
        @(negedge clk);
        e = (q_b.size() != 0) ? q_b.pop_front() : RST_EXP;
        n_chk++;
        if ({bus_b.an, bus_b.seg, bus_b.dp_out} !== {4'hF, 7'h7F, 1'b1}) begin
            n_fail++; $display("FAIL nd_reset got %h/%h/%b want f/7f/1", bus_b.an, bus_b.seg, bus_b.dp_out);
        end
        rst_b = 1'b0;
        have_prev = 1'b0; run = 0; prev_an = 4'hF;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            n_chk++;
            e = (q_b.size() != 0) ? q_b.pop_front() : RST_EXP;
            if ({bus_b.an, bus_b.seg, bus_b.dp_out} !== e) begin
                n_fail++; $display("FAIL nd_sb k=%0d got %h/%h/%b want %h/%h/%b", k, bus_b.an, bus_b.seg, bus_b.dp_out, e.an, e.seg, e.dp);
            end
            n_chk++;
            if (bus_b.an === 4'hF) begin
                n_fail++; $display("FAIL nd_alloff k=%0d got f want one anode on", k);
            end
            if (have_prev && bus_b.an === prev_an) run++;
            else begin
                if (have_prev) begin
                    n_chk++;
                    if (run != 2) begin n_fail++; $display("FAIL nd_run an=%h got %0d cycles want 2", prev_an, run); end
                end
                have_prev = 1'b1; prev_an = bus_b.an; run = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank_lz();
        test_all_zero();
        test_non_bcd_dp();
        test_reset_mid();
        test_no_dead();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
